// File: rtl/bcd_to_7segment_if.sv
// Digit/display bus between a driver and one seven-segment decoder.
interface bcd_to_7segment_if;
  logic [3:0] BCD;
  logic       en;
  logic       lamp_test;
  logic       blank;
  logic [6:0] segment7;
  logic       invalid;

  modport master (output BCD, en, lamp_test, blank, input segment7, invalid);
  modport slave  (input BCD, en, lamp_test, blank, output segment7, invalid);
endinterface

// File: rtl/bcd_to_7segment.sv
// Registered BCD/hex to seven-segment decoder with lamp test, blanking and
// optional common-anode inversion. Segment order {a,b,c,d,e,f,g}.
module bcd_to_7segment #(
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter bit BLANK_INVALID = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_to_7segment_if.slave      bus
);

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  logic [3:0] code;
  logic       loaded;
  logic [6:0] seg_q;
  logic       invalid_q;

  logic [3:0] nxt_code;
  logic       nxt_loaded;
  logic [6:0] glyph;
  logic [6:0] raw;

  // Output registers track the post-edge code so a load shows after one edge.
  assign nxt_code   = bus.en ? bus.BCD : code;
  assign nxt_loaded = loaded | bus.en;

  always_comb begin
    glyph = SEG_OFF;
    case (nxt_code)
      4'd0:  glyph = 7'h7E;
      4'd1:  glyph = 7'h30;
      4'd2:  glyph = 7'h6D;
      4'd3:  glyph = 7'h79;
      4'd4:  glyph = 7'h33;
      4'd5:  glyph = 7'h5B;
      4'd6:  glyph = 7'h5F;
      4'd7:  glyph = 7'h70;
      4'd8:  glyph = 7'h7F;
      4'd9:  glyph = 7'h7B;
      4'd10: glyph = BLANK_INVALID ? SEG_OFF : 7'h77;
      4'd11: glyph = BLANK_INVALID ? SEG_OFF : 7'h1F;
      4'd12: glyph = BLANK_INVALID ? SEG_OFF : 7'h4E;
      4'd13: glyph = BLANK_INVALID ? SEG_OFF : 7'h3D;
      4'd14: glyph = BLANK_INVALID ? SEG_OFF : 7'h4F;
      4'd15: glyph = BLANK_INVALID ? SEG_OFF : 7'h47;
      default: glyph = SEG_OFF;
    endcase
  end

  // Until the first load after reset the display stays dark, even though the
  // code register holds 0.
  always_comb begin
    raw = glyph;
    if (bus.lamp_test)    raw = SEG_ALL;
    else if (bus.blank)   raw = SEG_OFF;
    else if (!nxt_loaded) raw = SEG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code      <= 4'd0;
      loaded    <= 1'b0;
      seg_q     <= ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
      invalid_q <= 1'b0;
    end else begin
      code      <= nxt_code;
      loaded    <= nxt_loaded;
      seg_q     <= ACTIVE_LOW ? ~raw : raw;
      invalid_q <= (nxt_code > 4'd9);
    end
  end

  assign bus.segment7 = seg_q;
  assign bus.invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Directed bench for bcd_to_7segment: three parameter variants driven in
// lockstep, checked against a glyph-table display model every cycle.
module tb_bcd_to_7segment;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       en = 1'b0, lt = 1'b0, bl = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // v0: defaults, v1: hex glyphs, v2: active-low with blanking
  bcd_to_7segment_if if0 ();
  bcd_to_7segment_if if1 ();
  bcd_to_7segment_if if2 ();

  assign if0.BCD = bcd; assign if0.en = en; assign if0.lamp_test = lt; assign if0.blank = bl;
  assign if1.BCD = bcd; assign if1.en = en; assign if1.lamp_test = lt; assign if1.blank = bl;
  assign if2.BCD = bcd; assign if2.en = en; assign if2.lamp_test = lt; assign if2.blank = bl;

  bcd_to_7segment #(.ACTIVE_LOW(1'b0), .BLANK_INVALID(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  bcd_to_7segment #(.ACTIVE_LOW(1'b0), .BLANK_INVALID(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  bcd_to_7segment #(.ACTIVE_LOW(1'b1), .BLANK_INVALID(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  logic [6:0] dig [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [6:0] hexg [6] = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model: what the display shows, as of the last edge
  int  m_code = 0;
  bit  m_loaded = 0, m_lt = 0, m_bl = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_code = 0; m_loaded = 0; m_lt = 0; m_bl = 0;
    end else begin
      if (en) begin m_code = int'(bcd); m_loaded = 1; end
      m_lt = lt; m_bl = bl;
    end
  end

  function automatic logic [6:0] exp_seg(bit al, bit bi);
    logic [6:0] r;
    if (m_lt)              r = 7'h7F;
    else if (m_bl)         r = 7'h00;
    else if (!m_loaded)    r = 7'h00;
    else if (m_code < 10)  r = dig[m_code];
    else if (bi)           r = 7'h00;
    else                   r = hexg[m_code-10];
    return al ? ~r : r;
  endfunction

  function automatic logic exp_inv();
    return m_loaded && (m_code >= 10);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("v0_seg", {1'b0, if0.segment7}, {1'b0, exp_seg(1'b0, 1'b1)});
      chk("v1_seg", {1'b0, if1.segment7}, {1'b0, exp_seg(1'b0, 1'b0)});
      chk("v2_seg", {1'b0, if2.segment7}, {1'b0, exp_seg(1'b1, 1'b1)});
      chk("v0_inv", {7'd0, if0.invalid}, {7'd0, exp_inv()});
      chk("v1_inv", {7'd0, if1.invalid}, {7'd0, exp_inv()});
      chk("v2_inv", {7'd0, if2.invalid}, {7'd0, exp_inv()});
    end
  end

  // Set inputs, then let one edge pass; returns 1 time unit after that edge.
  task automatic apply(input logic [3:0] b, input logic e, input logic l, input logic k);
    bcd = b; en = e; lt = l; bl = k;
    @(posedge clk); #1;
  endtask

  logic [6:0] sweep [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_v0_seg", {1'b0, if0.segment7}, 8'h00);
    chk("rst_v2_seg", {1'b0, if2.segment7}, 8'h7F);
    chk("rst_inv",    {7'd0, if0.invalid}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // no load yet: display dark even with BCD present
    apply(4'd6, 1'b0, 1'b0, 1'b0);
    apply(4'd6, 1'b0, 1'b0, 1'b0);
    chk("noload_dark", {1'b0, if0.segment7}, 8'h00);

    for (int d = 0; d < 10; d++) begin
      apply(d[3:0], 1'b1, 1'b0, 1'b0);
      chk("sweep_v0", {1'b0, if0.segment7}, {1'b0, sweep[d]});
      chk("sweep_inv", {7'd0, if0.invalid}, 8'h00);
    end
    chk("v2_eight", {1'b0, if2.segment7}, 8'h04);  // ~7B after digit 9

    apply(4'd12, 1'b1, 1'b0, 1'b0);
    chk("c12_blank", {1'b0, if0.segment7}, 8'h00);
    chk("c12_hex",   {1'b0, if1.segment7}, 8'h4E);
    chk("c12_inv0",  {7'd0, if0.invalid}, 8'h01);
    chk("c12_inv1",  {7'd0, if1.invalid}, 8'h01);
    for (int d = 10; d < 16; d++) apply(d[3:0], 1'b1, 1'b0, 1'b0);
    chk("cF_hex", {1'b0, if1.segment7}, 8'h47);
    apply(4'd13, 1'b1, 1'b1, 1'b0);
    chk("lt_inv", {7'd0, if1.invalid}, 8'h01);

    apply(4'd5, 1'b1, 1'b0, 1'b0);
    apply(4'd8, 1'b0, 1'b0, 1'b0);
    apply(4'd8, 1'b0, 1'b0, 1'b0);
    chk("hold_5", {1'b0, if0.segment7}, 8'h5B);

    apply(4'd3, 1'b1, 1'b0, 1'b0);
    apply(4'd3, 1'b0, 1'b1, 1'b1);
    chk("lt_on", {1'b0, if0.segment7}, 8'h7F);
    apply(4'd3, 1'b0, 1'b0, 1'b1);
    chk("blank_on", {1'b0, if0.segment7}, 8'h00);
    apply(4'd3, 1'b0, 1'b0, 1'b0);
    chk("release", {1'b0, if0.segment7}, 8'h79);

    // code keeps loading underneath the mask
    apply(4'd2, 1'b1, 1'b0, 1'b1);
    apply(4'd9, 1'b0, 1'b0, 0);
    chk("load_masked", {1'b0, if0.segment7}, 8'h6D);

    apply(4'd8, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_v0", {1'b0, if0.segment7}, 8'h7F);
    chk("pre_rst_v2", {1'b0, if2.segment7}, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_v0",  {1'b0, if0.segment7}, 8'h00);
    chk("mid_rst_v2",  {1'b0, if2.segment7}, 8'h7F);
    chk("mid_rst_inv", {7'd0, if0.invalid}, 8'h00);
    #1 rst = 1'b0;
    apply(4'd4, 1'b0, 1'b0, 1'b0);
    chk("post_rst_dark", {1'b0, if0.segment7}, 8'h00);
    apply(4'd4, 1'b1, 1'b0, 1'b0);
    chk("post_rst_load", {1'b0, if0.segment7}, 8'h33);
    apply(4'd4, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
